change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 106 ++++++++++
 tb/tb_change_dispenser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a yen amount as 50/10-yen coin pulses.
// Pulses are paced by the hopper handshake plus a fixed idle gap.
module change_dispenser #(
  parameter int GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] amount,
  input  logic       hopper_rdy,
  output logic       coin_50_out,
  output logic       coin_10_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] remaining
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    PULSE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

  state_t     state, state_n;
  logic [6:0] rem, rem_n;
  logic [3:0] cnt, cnt_n;
  logic       err_n;
  logic       c50_n, c10_n;
  logic [6:0] amt_mod;
  logic [6:0] amt_rnd;

  assign amt_mod   = amount % 7'd10;
  assign amt_rnd   = amount - amt_mod;
  assign remaining = rem;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    cnt_n   = cnt;
    err_n   = err;
    c50_n   = 1'b0;
    c10_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          rem_n   = amt_rnd;
          err_n   = (amt_mod != 7'd0);
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (rem == 7'd0) begin
          state_n = DONE;
        end else if (hopper_rdy) begin
          state_n = PULSE;
          if (rem >= 7'd50) begin
            c50_n = 1'b1;
            rem_n = rem - 7'd50;
          end else begin
            c10_n = 1'b1;
            rem_n = rem - 7'd10;
          end
        end
      end
      PULSE: begin
        state_n = WAIT;
        cnt_n   = GAP_M1;
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = ISSUE;
        else cnt_n = cnt - 4'd1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs are registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= 7'd0;
      cnt         <= 4'd0;
      err         <= 1'b0;
      coin_50_out <= 1'b0;
      coin_10_out <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      cnt         <= cnt_n;
      err         <= err_n;
      coin_50_out <= c50_n;
      coin_10_out <= c10_n;
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a coin-queue model.
// Directed scenarios first, then random starts, stalls and resets.
module tb_change_dispenser;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] amount = 7'd0;
  logic       hopper_rdy = 1'b0;
  logic       coin_50_out, coin_10_out;
  logic       busy, done, err;
  logic [6:0] remaining;

  change_dispenser #(.GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .amount(amount), .hopper_rdy(hopper_rdy),
    .coin_50_out(coin_50_out), .coin_10_out(coin_10_out),
    .busy(busy), .done(done), .err(err),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
  endtask

  // model: a request is a queue of coin values plus a cooldown
  int m_busy, m_fin, m_cool, m_rem, m_err;
  int e_c50, e_c10, e_done;
  int m_q[$];
  int n_done;

  task automatic m_reset();
    m_busy = 0; m_fin = 0; m_cool = 0;
    m_rem = 0; m_err = 0;
    e_c50 = 0; e_c10 = 0; e_done = 0;
    m_q.delete();
  endtask

  task automatic m_edge();
    int c;
    e_c50 = 0; e_c10 = 0; e_done = 0;
    if (rst) begin
      m_reset();
    end else if (m_busy == 0) begin
      if (start) begin
        m_busy = 1;
        m_rem = (int'(amount) / 10) * 10;
        m_err = (int'(amount) % 10 != 0) ? 1 : 0;
        m_q.delete();
        for (int i = 0; i < m_rem / 50; i++) m_q.push_back(50);
        for (int i = 0; i < (m_rem % 50) / 10; i++) m_q.push_back(10);
        m_cool = 0;
        m_fin = 0;
      end
    end else if (m_fin) begin
      m_busy = 0;
      m_fin = 0;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (m_q.size() == 0) begin
      e_done = 1;
      m_fin = 1;
    end else if (hopper_rdy) begin
      c = m_q.pop_front();
      m_rem -= c;
      if (c == 50) e_c50 = 1;
      else e_c10 = 1;
      m_cool = GAP + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".c50"}, int'(coin_50_out), e_c50);
    chk({tag, ".c10"}, int'(coin_10_out), e_c10);
    chk({tag, ".busy"}, int'(busy), m_busy);
    chk({tag, ".done"}, int'(done), e_done);
    chk({tag, ".err"}, int'(err), m_err);
    chk({tag, ".rem"}, int'(remaining), m_rem);
  endtask

  // one clock: model steps at the edge, outputs checked at negedge
  task automatic cyc(input string tag);
    @(posedge clk);
    m_edge();
    if (e_done) n_done++;
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic req(input int amt);
    start = 1'b1;
    amount = 7'(amt);
  endtask

  task automatic idle_in();
    start = 1'b0;
  endtask

  task automatic async_rst(input string tag);
    #2 rst = 1'b1;
    #1;
    m_reset();
    compare_all(tag);
  endtask

  initial begin
    m_reset();
    n_done = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) cyc("reset");
    rst = 1'b0;
    hopper_rdy = 1'b1;
    for (int i = 0; i < 4; i++) cyc("idle");

    // 60 yen: 50 then 10, four cycles apart
    n_done = 0;
    req(60);
    cyc("a60");
    idle_in();
    for (int i = 0; i < 12; i++) cyc("a60");
    chk("a60.ndone", n_done, 1);

    // 127 yen: err set, 50,50,10,10
    n_done = 0;
    req(127);
    cyc("a127");
    idle_in();
    for (int i = 0; i < 20; i++) cyc("a127");
    chk("a127.ndone", n_done, 1);
    chk("a127.err", int'(err), 1);

    // 10 yen with hopper stalled five cycles
    n_done = 0;
    hopper_rdy = 1'b0;
    req(10);
    cyc("stall");
    idle_in();
    for (int i = 0; i < 5; i++) cyc("stall");
    hopper_rdy = 1'b1;
    for (int i = 0; i < 8; i++) cyc("stall");
    chk("stall.ndone", n_done, 1);

    // zero amount: done with no coins
    n_done = 0;
    req(0);
    cyc("zero");
    idle_in();
    for (int i = 0; i < 4; i++) cyc("zero");
    chk("zero.ndone", n_done, 1);

    // second start while busy, then reset during the gap
    n_done = 0;
    req(60);
    cyc("abort");
    req(100);
    cyc("abort");
    cyc("abort");
    idle_in();
    cyc("abort");
    async_rst("abort.rst");
    cyc("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc("abort.post");
    chk("abort.ndone", n_done, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(3) == 0);
      amount = 7'($urandom_range(127));
      hopper_rdy = ($urandom_range(9) < 7);
      if ($urandom_range(199) == 0) begin
        async_rst("rnd.rst");
        cyc("rnd");
        @(negedge clk);
        rst = 1'b0;
      end
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
